// File: rtl/boreal_multi_watchdog.sv
// Multi-channel heartbeat watchdog: per-channel late/early fault detection,
// sticky flags, aggregated halt and first-faulting-channel capture.
module boreal_multi_watchdog #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYC    = 25_000_000,
  parameter int unsigned WINDOW_MIN_CYC = 0,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] heartbeat,
  input  logic [NUM_CH-1:0] clear,
  output logic [NUM_CH-1:0] stall,
  output logic [NUM_CH-1:0] early_fault,
  output logic              halt,
  output logic              first_valid,
  output logic [CH_W-1:0]   first_ch
);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_TRIPPED  = 2'd2,
    S_EARLY    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] WINDOW_V  = CNT_W'(WINDOW_MIN_CYC);
  localparam logic             WINDOW_ON = (WINDOW_MIN_CYC != 0);

  state_t            r_state   [NUM_CH];
  state_t            w_state_nxt [NUM_CH];
  logic [CNT_W-1:0]  r_cnt     [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_stall;
  logic [NUM_CH-1:0] r_early;
  logic [NUM_CH-1:0] w_enter;
  logic              r_first_valid;
  logic [CH_W-1:0]   r_first_ch;
  logic              w_first_valid_nxt;
  logic [CH_W-1:0]   w_first_ch_nxt;
  logic              w_free;
  logic              w_found;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (!enable[i]) begin
        w_state_nxt[i] = S_DISARMED;
        w_cnt_nxt[i]   = '0;
      end else begin
        case (r_state[i])
          S_DISARMED: begin
            w_state_nxt[i] = S_ARMED;
            w_cnt_nxt[i]   = '0;
          end
          S_ARMED: begin
            if (clear[i]) begin
              w_cnt_nxt[i] = '0;
            end else if (heartbeat[i]) begin
              if (WINDOW_ON && (r_cnt[i] < WINDOW_V)) w_state_nxt[i] = S_EARLY;
              else                                     w_cnt_nxt[i]   = '0;
            end else if (r_cnt[i] < TIMEOUT_V) begin
              w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end else begin
              w_state_nxt[i] = S_TRIPPED;
            end
          end
          default: begin
            if (clear[i]) begin
              w_state_nxt[i] = S_ARMED;
              w_cnt_nxt[i]   = '0;
            end
          end
        endcase
      end
      w_enter[i] = (r_state[i] == S_ARMED) &&
                   ((w_state_nxt[i] == S_TRIPPED) || (w_state_nxt[i] == S_EARLY));
    end
  end

  // Capture slot is free when nothing is latched or every flag has gone low;
  // a fault entering on that same edge is latched instead of dropping.
  always_comb begin
    w_first_valid_nxt = r_first_valid;
    w_first_ch_nxt    = r_first_ch;
    w_found           = 1'b0;
    w_free            = !r_first_valid || ((r_stall | r_early) == '0);
    if (w_free) begin
      w_first_valid_nxt = 1'b0;
      w_first_ch_nxt    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_enter[i] && !w_found) begin
          w_found           = 1'b1;
          w_first_valid_nxt = 1'b1;
          w_first_ch_nxt    = CH_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_state[i] <= S_DISARMED;
        r_cnt[i]   <= '0;
      end
      r_stall       <= '0;
      r_early       <= '0;
      r_first_valid <= 1'b0;
      r_first_ch    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_stall[i] <= (w_state_nxt[i] == S_TRIPPED);
        r_early[i] <= (w_state_nxt[i] == S_EARLY);
      end
      r_first_valid <= w_first_valid_nxt;
      r_first_ch    <= w_first_ch_nxt;
    end
  end

  assign stall       = r_stall;
  assign early_fault = r_early;
  assign halt        = |(r_stall | r_early);
  assign first_valid = r_first_valid;
  assign first_ch    = r_first_ch;

endmodule

// File: tb/tb_boreal_multi_watchdog.sv
// Directed-vector bench for boreal_multi_watchdog (NUM_CH=4, TIMEOUT=8, WINDOW=3).
module tb_boreal_multi_watchdog;

  logic       clk;
  logic       rst_n;
  logic [3:0] enable;
  logic [3:0] heartbeat;
  logic [3:0] clear;
  logic [3:0] stall;
  logic [3:0] early_fault;
  logic       halt;
  logic       first_valid;
  logic [1:0] first_ch;

  int unsigned n_vec;
  int unsigned n_err;

  boreal_multi_watchdog #(
    .NUM_CH         (4),
    .CNT_W          (32),
    .TIMEOUT_CYC    (8),
    .WINDOW_MIN_CYC (3)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .heartbeat   (heartbeat),
    .clear       (clear),
    .stall       (stall),
    .early_fault (early_fault),
    .halt        (halt),
    .first_valid (first_valid),
    .first_ch    (first_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_stall, input logic [3:0] e_early,
                         input logic e_halt, input logic e_fv, input logic [1:0] e_fc);
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".early"}, 32'(early_fault), 32'(e_early));
    chk({tag, ".halt"},  32'(halt), 32'(e_halt));
    chk({tag, ".fv"},    32'(first_valid), 32'(e_fv));
    chk({tag, ".fc"},    32'(first_ch), 32'(e_fc));
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; enable = '0; heartbeat = '0; clear = '0;
    #2;
    chk_all("reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ch0 heartbeat every 5 cycles: never faults
    enable = 4'b0001;
    tick();
    for (int k = 1; k <= 100; k++) begin
      heartbeat = (k % 5 == 0) ? 4'b0001 : 4'b0000;
      tick();
      chk("hb_ok", {29'd0, |stall, |early_fault, halt}, 32'd0);
    end
    heartbeat = '0;
    enable = '0;
    tick();

    // ch1 timeout: stall exactly 9 edges after arming
    enable = 4'b0010;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("ch1_pre", 32'(stall), 32'd0);
    end
    tick();
    chk_all("ch1_trip", 4'b0010, 4'h0, 1'b1, 1'b1, 2'd1);

    // disarm while tripped, then re-arm and trip again
    enable = '0;
    tick();
    chk_all("ch1_dis", 4'h0, 4'h0, 1'b0, 1'b1, 2'd1);
    tick();
    chk_all("ch1_drop", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    enable = 4'b0010;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("ch1_re_pre", 32'(stall), 32'd0);
    end
    tick();
    chk_all("ch1_retrip", 4'b0010, 4'h0, 1'b1, 1'b1, 2'd1);
    enable = '0;
    tick(); tick();

    // ch2 early heartbeat
    enable = 4'b0100;
    tick();
    tick(); tick(); tick();
    heartbeat = 4'b0100;
    tick();
    chk("ch2_hb_ok", 32'(early_fault), 32'd0);
    heartbeat = '0;
    tick();
    heartbeat = 4'b0100;
    tick();
    chk_all("ch2_early", 4'h0, 4'b0100, 1'b1, 1'b1, 2'd2);
    tick();
    chk_all("ch2_ignore", 4'h0, 4'b0100, 1'b1, 1'b1, 2'd2);
    clear = 4'b0100;
    tick();
    chk_all("ch2_clr", 4'h0, 4'h0, 1'b0, 1'b1, 2'd2);
    clear = '0; heartbeat = '0;
    tick();
    chk_all("ch2_fvdrop", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("ch2_armed", 32'(stall), 32'd0);
    end
    tick();
    chk_all("ch2_trip", 4'b0100, 4'h0, 1'b1, 1'b1, 2'd2);
    enable = '0;
    tick(); tick();
    chk_all("ch2_off", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);

    // ch0 and ch3 simultaneous timeout: lowest index wins
    enable = 4'b1001;
    tick();
    for (int k = 1; k <= 8; k++) tick();
    tick();
    chk_all("dual_trip", 4'b1001, 4'h0, 1'b1, 1'b1, 2'd0);
    clear = 4'b0001;
    tick();
    clear = '0;
    chk_all("dual_clr0", 4'b1000, 4'h0, 1'b1, 1'b1, 2'd0);
    tick();
    chk_all("dual_hold", 4'b1000, 4'h0, 1'b1, 1'b1, 2'd0);
    clear = 4'b1000;
    tick();
    clear = '0;
    chk_all("dual_clr3", 4'h0, 4'h0, 1'b0, 1'b1, 2'd0);
    tick();
    chk_all("dual_fvdrop", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);

    // ch0 counts on to a trip (cnt 3 -> 8 -> trip) while ch3 is mid-count
    for (int k = 1; k <= 5; k++) tick();
    chk("pre_rst_stall", 32'(stall), 32'd0);
    tick();
    chk_all("pre_rst_trip", 4'b0001, 4'h0, 1'b1, 1'b1, 2'd0);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    enable = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("post_rst_idle", {28'd0, stall | early_fault}, 32'd0);
    end
    enable = 4'b1000;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("ch3_pre", 32'(stall), 32'd0);
    end
    tick();
    chk_all("ch3_trip", 4'b1000, 4'h0, 1'b1, 1'b1, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
